booth_pp_sequencer: RTL and testbench



---
 rtl/booth_pkg.sv | 31 +++
 rtl/booth_digit_encoder.sv | 26 ++
 rtl/booth_pp_sequencer.sv | 152 +++++++++++++++
 tb/tb_booth_pp_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit recoding rule for the
// booth_pp_sequencer slice.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Triple is {Y[2i+1], Y[2i], Y[2i-1]}; 111 is deliberately plain zero.
  function automatic booth_digit_t booth_encode(input logic [2:0] triple);
    booth_digit_t d;
    case (triple)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Combinational radix-4 Booth digit encoder: magnitude one-hot (one/two)
// plus a sign flag that is never set for a zero digit.
module booth_digit_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triple,
  output logic       one,
  output logic       two,
  output logic       neg
);

  // Decode the recoded digit into magnitude select and sign.
  always_comb begin
    one = 1'b0;
    two = 1'b0;
    neg = 1'b0;
    case (booth_encode(triple))
      BD_POS1: one = 1'b1;
      BD_POS2: two = 1'b1;
      BD_NEG1: begin one = 1'b1; neg = 1'b1; end
      BD_NEG2: begin two = 1'b1; neg = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_pp_sequencer.sv
// Sequential radix-4 Booth partial-product source. Accepts one X/Y pair in
// IDLE, then presents one un-negated partial product per handshake in EMIT.
// Optional build macro BOOTH_SKIP_ZERO_EN: zero digits are skipped and only
// nonzero digits (or a single zero digit 0 when all are zero) are emitted.
module booth_pp_sequencer
  import booth_pkg::*;
#(
  parameter int MCAND_W  = 16,
  parameter int MPLIER_W = 16,
  parameter int PP_WIDTH = MCAND_W + 3,
  parameter int IDX_W    = $clog2(MPLIER_W / 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MCAND_W-1:0]  mcand,
  input  logic [MPLIER_W-1:0] mplier,
  output logic                pp_valid,
  input  logic                pp_ready,
  output logic [PP_WIDTH-1:0] pp,
  output logic                pp_sign,
  output logic [IDX_W-1:0]    pp_idx,
  output logic                pp_last
);

  localparam int unsigned NDIG = MPLIER_W / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t                     state_q, state_d;
  logic [MCAND_W-1:0]         x_q;
  logic [MPLIER_W-1:0]        y_q;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           first_idx, next_idx;
  logic                       last;
  logic [MPLIER_W:0]          y_ext;
  logic [2:0]                 cur_triple;
  logic                       cur_one, cur_two, cur_neg;
  logic signed [PP_WIDTH-1:0] x_ext;
  logic [PP_WIDTH-1:0]        mag;

  assign y_ext      = {y_q, 1'b0};
  assign cur_triple = 3'(y_ext >> {idx_q, 1'b0});
  assign x_ext      = PP_WIDTH'(signed'(x_q));

  booth_digit_encoder u_enc (
    .triple (cur_triple),
    .one    (cur_one),
    .two    (cur_two),
    .neg    (cur_neg)
  );

  // Magnitude select: |digit| * sext(X); 2*X fits because PP_WIDTH > MCAND_W+1.
  always_comb begin
    mag = '0;
    if (cur_two)      mag = x_ext << 1;
    else if (cur_one) mag = x_ext;
  end

`ifdef BOOTH_SKIP_ZERO_EN
  // The scan looks at the incoming multiplier while idle so the first
  // nonzero digit is already selected on the cycle after acceptance.
  logic [MPLIER_W-1:0] scan_y;
  logic [MPLIER_W:0]   scan_ext;
  logic [NDIG-1:0]     s_one, s_two, s_neg_unused, nz;
  logic                has_next;

  assign scan_y   = (state_q == IDLE) ? mplier : y_q;
  assign scan_ext = {scan_y, 1'b0};

  for (genvar g = 0; g < NDIG; g++) begin : g_scan
    booth_digit_encoder u_scan_enc (
      .triple (scan_ext[2*g +: 3]),
      .one    (s_one[g]),
      .two    (s_two[g]),
      .neg    (s_neg_unused[g])
    );
  end

  assign nz = s_one | s_two;

  // Priority find of the lowest nonzero digit overall and above idx_q.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int unsigned j = NDIG; j > 0; j--) begin
      if (nz[j-1]) first_idx = IDX_W'(j - 1);
      if (nz[j-1] && ((j - 1) > 32'(idx_q))) begin
        next_idx = IDX_W'(j - 1);
        has_next = 1'b1;
      end
    end
  end

  assign last = !has_next;
`else
  assign first_idx = '0;
  assign next_idx  = idx_q + IDX_W'(1);
  assign last      = (idx_q == LAST_IDX);
`endif

  // Next-state and digit-index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          idx_d   = first_idx;
        end
      end
      EMIT: begin
        if (pp_ready) begin
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and operand registers; operands load only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && in_valid) begin
        x_q <= mcand;
        y_q <= mplier;
      end
    end
  end

  assign in_ready = (state_q == IDLE);
  assign pp_valid = (state_q == EMIT);
  assign pp       = pp_valid ? mag : '0;
  assign pp_sign  = pp_valid && cur_neg;
  assign pp_idx   = idx_q;
  assign pp_last  = pp_valid && last;

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Self-checking bench for booth_pp_sequencer with an arithmetic Booth model.
// Honours BOOTH_SKIP_ZERO_EN when the design is built with it.
module tb_booth_pp_sequencer;

  localparam int MCAND_W  = 16;
  localparam int MPLIER_W = 16;
  localparam int PP_WIDTH = MCAND_W + 3;
  localparam int IDX_W    = 3;
  localparam int NDIG     = MPLIER_W / 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [MCAND_W-1:0]  mcand = '0;
  logic [MPLIER_W-1:0] mplier = '0;
  logic                pp_valid;
  logic                pp_ready = 1'b0;
  logic [PP_WIDTH-1:0] pp;
  logic                pp_sign;
  logic [IDX_W-1:0]    pp_idx;
  logic                pp_last;

  int checks = 0;
  int failures = 0;

  booth_pp_sequencer #(
    .MCAND_W  (MCAND_W),
    .MPLIER_W (MPLIER_W),
    .PP_WIDTH (PP_WIDTH),
    .IDX_W    (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mcand    (mcand),
    .mplier   (mplier),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp       (pp),
    .pp_sign  (pp_sign),
    .pp_idx   (pp_idx),
    .pp_last  (pp_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Run one operation: accept operands, then consume every expected digit,
  // optionally stalling (pp_ready low) with in_valid noise at stall_idx.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input int stall_idx, input int stall_n, input bit rand_stall);
    int          e_idx[$];
    int          e_pp[$];
    bit          e_sign[$];
    logic [16:0] ye;
    int          d, waitc, stalls;
    longint      sum, v, prod;
    logic [PP_WIDTH-1:0] ppv;

    // Reference: d_i = -2*Y[2i+1] + Y[2i] + Y[2i-1], pp = |d_i|*X.
    ye = {y, 1'b0};
    for (int i = 0; i < NDIG; i++) begin
      d = -2 * int'(ye[2*i+2]) + int'(ye[2*i+1]) + int'(ye[2*i]);
`ifdef BOOTH_SKIP_ZERO_EN
      if (d == 0) continue;
`endif
      e_idx.push_back(i);
      e_pp.push_back((d < 0 ? -d : d) * int'(signed'(x)));
      e_sign.push_back(d < 0);
    end
    if (e_idx.size() == 0) begin
      e_idx.push_back(0);
      e_pp.push_back(0);
      e_sign.push_back(1'b0);
    end

    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
      return;
    end

    mcand = x; mplier = y; in_valid = 1'b1; pp_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mcand = 16'($urandom); mplier = 16'($urandom);

    sum = 0;
    for (int k = 0; k < e_idx.size(); k++) begin
      if (e_idx[k] == stall_idx) stalls = stall_n;
      else if (rand_stall) stalls = $urandom_range(0, 2);
      else stalls = 0;
      ppv = PP_WIDTH'(e_pp[k]);
      for (int s = 0; s <= stalls; s++) begin
        pp_ready = (s == stalls);
        if (s < stalls && stall_idx >= 0) begin
          in_valid = 1'b1; mcand = 16'($urandom); mplier = 16'($urandom);
        end
        checks++;
        if (pp_valid !== 1'b1) begin
          failures++;
          $display("FAIL pp_valid[k=%0d]: got %b required 1", k, pp_valid);
        end
        checks++;
        if (pp !== ppv) begin
          failures++;
          $display("FAIL pp[k=%0d x=%h y=%h]: got %h required %h", k, x, y, pp, ppv);
        end
        checks++;
        if (pp_sign !== e_sign[k]) begin
          failures++;
          $display("FAIL pp_sign[k=%0d x=%h y=%h]: got %b required %b", k, x, y, pp_sign, e_sign[k]);
        end
        checks++;
        if (pp_idx !== IDX_W'(e_idx[k])) begin
          failures++;
          $display("FAIL pp_idx[k=%0d y=%h]: got %0d required %0d", k, y, pp_idx, e_idx[k]);
        end
        checks++;
        if (pp_last !== (k == e_idx.size() - 1)) begin
          failures++;
          $display("FAIL pp_last[k=%0d y=%h]: got %b required %b", k, y, pp_last, (k == e_idx.size() - 1));
        end
        if (s == stalls) begin
          v = longint'(signed'(pp));
          if (pp_sign) v = -v;
          sum += v <<< (2 * int'(pp_idx));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    pp_ready = 1'b0;

    checks++;
    if (pp_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL op_end[y=%h]: pp_valid=%b in_ready=%b required 0/1", y, pp_valid, in_ready);
    end
    prod = longint'(signed'(x)) * longint'(signed'(y));
    checks++;
    if (sum !== prod) begin
      failures++;
      $display("FAIL product[x=%h y=%h]: got %0d required %0d", x, y, sum, prod);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, pp_valid, pp, pp_sign, pp_idx, pp_last} !== {1'b1, 1'b0, 19'd0, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b pp=%h sign=%b idx=%0d last=%b required 1 0 0 0 0 0",
               in_ready, pp_valid, pp, pp_sign, pp_idx, pp_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || pp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: in_ready=%b pp_valid=%b required 1/0", in_ready, pp_valid);
    end
  endtask

  task automatic test_directed();
    run_op(16'h0003, 16'h0006, -1, 0, 1'b0);
    run_op(16'h8000, 16'h8000, -1, 0, 1'b0);
    run_op(16'h0005, 16'hFFFF, -1, 0, 1'b0);
    run_op(16'h1234, 16'h0000, -1, 0, 1'b0);
    run_op(16'h8000, 16'hAAAA, -1, 0, 1'b0);
    run_op(16'h7FFF, 16'h7FFF, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(16'h0003, 16'h0006, 1, 3, 1'b0);
  endtask

  task automatic test_mid_reset();
    mcand = 16'h0011; mplier = 16'h5555; in_valid = 1'b1; pp_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (pp_valid !== 1'b1 || pp_idx !== 3'd3) begin
      failures++;
      $display("FAIL mid_reset_reach: pp_valid=%b pp_idx=%0d required 1/3", pp_valid, pp_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (pp_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_abort: pp_valid=%b in_ready=%b required 0/1", pp_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (pp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_quiet: pp_valid=%b required 0", pp_valid);
    end
    pp_ready = 1'b0;
    run_op(16'h0003, 16'h0006, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_op(16'($urandom), 16'($urandom), -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] y;
    for (int n = 0; n < 40; n++) begin
      y = 16'($urandom);
      if ((n % 5) == 0) y = y & 16'h0F0F;
      run_op(16'($urandom), y, -1, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
